// File: rtl/rvm_mem_responder_if.sv
// Core memory handshake bundle: the initiator drives a request and holds it;
// the responder answers with a one-cycle grant carrying read data or a fault.
interface rvm_mem_responder_if;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_busy;

  modport master (
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_strb,
    input  mem_gnt, mem_rdata, mem_error, mem_busy
  );

  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_strb,
    output mem_gnt, mem_rdata, mem_error, mem_busy
  );
endinterface

// File: rtl/rvm_mem_responder.sv
// Word-organised storage behind the core memory handshake, with a fixed number
// of wait states per access and a fault for misaligned or out-of-range words.
module rvm_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  rvm_mem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  // Only meaningful when WAIT_CYCLES > 0; the WAIT state is never entered otherwise.
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_capture;

  logic          r_wen;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_strb;

  logic          r_gnt;
  logic          r_error;
  logic          r_busy;
  logic [31:0]   r_rdata;

  logic [31:0]   r_mem [DEPTH];

  logic          w_wen_sel;
  logic [31:0]   w_addr_sel;
  logic          w_fault;
  logic [AW-1:0] w_idx;

  // In IDLE the live bus request is decoded so a zero-wait access can respond next cycle.
  assign w_wen_sel  = (r_state == IDLE) ? bus.mem_wen  : r_wen;
  assign w_addr_sel = (r_state == IDLE) ? bus.mem_addr : r_addr;
  assign w_fault    = (w_addr_sel[1:0] != 2'b00) || (w_addr_sel[31:2] >= 30'(DEPTH));
  assign w_idx      = w_addr_sel[AW+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_req) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_next = RESP;
        else             w_cnt_next   = r_cnt - CW'(1);
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Captured request and registered response, valid only during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_gnt   <= 1'b0;
      r_error <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_capture) begin
        r_wen   <= bus.mem_wen;
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
        r_strb  <= bus.mem_strb;
      end
      r_busy  <= (w_state_next != IDLE);
      r_gnt   <= (w_state_next == RESP);
      r_error <= (w_state_next == RESP) && w_fault;
      r_rdata <= ((w_state_next == RESP) && !w_fault && !w_wen_sel) ? r_mem[w_idx] : '0;
    end
  end

  // Storage is not reset; a write lands on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if ((r_state == RESP) && r_wen && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign bus.mem_gnt   = r_gnt;
  assign bus.mem_error = r_error;
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_busy  = r_busy;
endmodule

// File: doc/rvm_mem_responder.md
RVM_MEM_RESPONDER -- requirements
Module: rvm_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit storage words (power of two, 4..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: wait states inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-005 SHALL have port mem_req  input  1  initiator request valid.
REQ-006 SHALL have port mem_wen  input  1  1 = write, 0 = read.
REQ-007 SHALL have port mem_addr  input  32  byte address.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_strb  input  4  write byte enables; bit n selects byte n.
REQ-010 SHALL have port mem_gnt  output  1  response valid, one-cycle pulse.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_gnt=1.
REQ-012 SHALL have port mem_error  output  1  access fault, valid while mem_gnt=1.
REQ-013 SHALL have port mem_busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the responder side of the core memory handshake: the initiator holds mem_req and all request fields stable until it samples mem_gnt=1.
REQ-015 SHALL use the states IDLE, WAIT, RESP, with state held in a register updated on the rising edge of clk.
REQ-016 IDLE with mem_req=1 SHALL capture wen, addr, wdata and strb, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0); with mem_req=0 it SHALL stay in IDLE.
REQ-017 On entry to WAIT, a wait counter SHALL load WAIT_CYCLES-1 and decrement each cycle; WAIT SHALL go to RESP in the cycle the counter is 0.
REQ-018 RESP SHALL last exactly one cycle with mem_gnt=1, then go to IDLE unconditionally; the minimum request spacing is therefore one IDLE cycle.
REQ-019 Latency SHALL be WAIT_CYCLES+1 cycles from the IDLE cycle that samples mem_req=1 to the mem_gnt cycle.
REQ-020 mem_req changes while in WAIT or RESP SHALL be ignored; only the captured request is serviced.
REQ-021 A fault SHALL be flagged when captured addr[1:0]!=0 or addr[31:2] >= DEPTH.
REQ-022 On a fault, RESP SHALL drive mem_error=1 and mem_rdata=0, and no storage SHALL be written.
REQ-023 A non-faulting read SHALL drive mem_rdata = storage[addr[31:2]] (full word, mem_strb ignored) and mem_error=0.
REQ-024 A non-faulting write SHALL update only the byte lanes with strb=1, on the clock edge ending RESP, and SHALL drive mem_rdata=0 and mem_error=0.
REQ-025 A write with strb=4'b0000 SHALL complete normally with mem_gnt and leave storage unchanged.
REQ-026 A read issued immediately after a write to the same word SHALL return the updated value.
REQ-027 Outside RESP, mem_gnt, mem_error and mem_rdata SHALL all be 0.
REQ-028 mem_busy SHALL be 1 exactly when the state is WAIT or RESP.

Reset
REQ-029 While reset=1 (asynchronously): state SHALL be IDLE, wait counter 0, captured request cleared, mem_gnt=0, mem_error=0, mem_rdata=0, mem_busy=0.
REQ-030 Reset asserted in WAIT or RESP SHALL abandon the request with no gnt and no storage write; storage contents SHALL NOT be altered by reset.
REQ-031 After reset deassertion, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 WAIT_CYCLES=1: write addr 0x10, wdata 0xDEADBEEF, strb 4'hF, then read 0x10 -> each gnt 2 cycles after request sampled; read returns 0xDEADBEEF, mem_error=0.
REQ-033 Write 0x11223344 to 0x20, then write 0xAABBCCDD with strb 4'b0101, then read -> 0x11BB33DD.
REQ-034 Read addr 0x3 (misaligned) and read addr 4*DEPTH -> mem_gnt with mem_error=1 and mem_rdata=0; a following read of 0x0 returns its prior contents.
REQ-035 WAIT_CYCLES=0: back-to-back requests with mem_req held high -> gnt every second cycle and mem_busy toggling 1,0.
REQ-036 Assert reset during WAIT of a write to 0x40 -> no mem_gnt and mem_busy=0 immediately; after reset, a read of 0x40 returns its pre-write value.
REQ-037 In WAIT, change mem_addr and mem_wdata -> the response and storage reflect the originally captured request only.
